// File: rtl/map_write_arbiter_if.sv
// Write-request bundle between the map requesters and map_write_arbiter,
// plus the registered write port the arbiter drives into map_mem.
interface map_write_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 2
);
    logic                          flush;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            wr_ack;
    logic                          we;
    logic [ADDR_WIDTH-1:0]         wr_addr;
    logic [DATA_WIDTH-1:0]         wr_data;
    logic                          busy;

    modport slave (
        input  flush, req_valid, req_addr, req_data,
        output req_ready, wr_ack, we, wr_addr, wr_data, busy
    );

    modport master (
        output flush, req_valid, req_addr, req_data,
        input  req_ready, wr_ack, we, wr_addr, wr_data, busy
    );
endinterface

// File: rtl/map_write_arbiter.sv
// Round-robin arbiter serialising tile writes into the single map_mem write port.
// Optional macro MAPWR_BOMB_PRIO_EN: bomb slots 0/1 get fixed priority above round-robin.
module map_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    map_write_arbiter_if.slave  bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    typedef enum logic {
        SLOT_EMPTY   = 1'b0,
        SLOT_PENDING = 1'b1
    } slot_state_t;

    slot_state_t           r_state     [NUM_REQ];
    slot_state_t           w_state_nxt [NUM_REQ];
    logic [ADDR_WIDTH-1:0] r_slot_addr [NUM_REQ];
    logic [DATA_WIDTH-1:0] r_slot_data [NUM_REQ];

    logic [PTR_W-1:0]      r_rr_ptr;
    logic [PTR_W-1:0]      w_rr_ptr_nxt;

    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [NUM_REQ-1:0]    r_wr_ack;

    logic [NUM_REQ-1:0]    w_pending;
    logic [NUM_REQ-1:0]    w_accept;
    logic [NUM_REQ-1:0]    w_grant_oh;
    logic                  w_grant_vld;
    logic                  w_grant_rr;
    logic [PTR_W-1:0]      w_grant_idx;
    logic [ADDR_WIDTH-1:0] w_grant_addr;
    logic [DATA_WIDTH-1:0] w_grant_data;

    always_comb begin
        w_pending = '0;
        w_accept  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_pending[i] = (r_state[i] == SLOT_PENDING);
            w_accept[i]  = ~bus.flush & bus.req_valid[i] & ~w_pending[i];
        end
    end

    // Scan starts at rr_ptr; the one-bit-wider sum lets us wrap for any NUM_REQ.
    always_comb begin
        logic [PTR_W:0] v_idx;
        v_idx       = '0;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            v_idx = {1'b0, r_rr_ptr} + (PTR_W+1)'(j);
            if (v_idx >= (PTR_W+1)'(NUM_REQ)) begin
                v_idx = v_idx - (PTR_W+1)'(NUM_REQ);
            end
            if (!w_grant_vld && w_pending[v_idx[PTR_W-1:0]]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = v_idx[PTR_W-1:0];
            end
        end
        w_grant_rr = w_grant_vld;
`ifdef MAPWR_BOMB_PRIO_EN
        // Bomb tier overrides round-robin and leaves rr_ptr untouched.
        if (w_pending[0]) begin
            w_grant_vld = 1'b1;
            w_grant_idx = '0;
            w_grant_rr  = 1'b0;
        end else if (w_pending[1]) begin
            w_grant_vld = 1'b1;
            w_grant_idx = PTR_W'(1);
            w_grant_rr  = 1'b0;
        end
`endif
    end

    always_comb begin
        w_grant_oh   = '0;
        w_grant_addr = '0;
        w_grant_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_grant_vld && (w_grant_idx == PTR_W'(i))) begin
                w_grant_oh[i] = 1'b1;
                w_grant_addr  = r_slot_addr[i];
                w_grant_data  = r_slot_data[i];
            end
        end
    end

    always_comb begin
        w_rr_ptr_nxt = r_rr_ptr;
        if (bus.flush) begin
            w_rr_ptr_nxt = '0;
        end else if (w_grant_rr) begin
            w_rr_ptr_nxt = (w_grant_idx == LAST_IDX) ? '0 : w_grant_idx + 1'b1;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_state_nxt[i] = r_state[i];
            if (bus.flush) begin
                w_state_nxt[i] = SLOT_EMPTY;
            end else begin
                case (r_state[i])
                    SLOT_EMPTY:   if (w_accept[i])   w_state_nxt[i] = SLOT_PENDING;
                    SLOT_PENDING: if (w_grant_oh[i]) w_state_nxt[i] = SLOT_EMPTY;
                    default:                         w_state_nxt[i] = SLOT_EMPTY;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                r_state[i]     <= SLOT_EMPTY;
                r_slot_addr[i] <= '0;
                r_slot_data[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                r_state[i] <= w_state_nxt[i];
                if (w_accept[i]) begin
                    r_slot_addr[i] <= bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    r_slot_data[i] <= bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rr_ptr  <= '0;
            r_we      <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wr_ack  <= '0;
        end else begin
            r_rr_ptr <= w_rr_ptr_nxt;
            if (bus.flush) begin
                r_we     <= 1'b0;
                r_wr_ack <= '0;
            end else begin
                r_we     <= w_grant_vld;
                r_wr_ack <= w_grant_oh;
                if (w_grant_vld) begin
                    r_wr_addr <= w_grant_addr;
                    r_wr_data <= w_grant_data;
                end
            end
        end
    end

    assign bus.req_ready = ~w_pending;
    assign bus.wr_ack    = r_wr_ack;
    assign bus.we        = r_we;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;
    assign bus.busy      = (|w_pending) | r_we;

endmodule

// File: tb/tb_map_write_arbiter.sv
// Directed bench for map_write_arbiter; expectations follow MAPWR_BOMB_PRIO_EN when defined.
module tb_map_write_arbiter;
    localparam int NR = 4;
    localparam int AW = 8;
    localparam int DW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    map_write_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    map_write_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.flush     = 1'b0;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_valid[i]          = 1'b1;
        bus.req_addr[i*AW +: AW]  = a;
        bus.req_data[i*DW +: DW]  = d;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bus.we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", bus.we); end
        n_checks++; if (bus.wr_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h expected 00", bus.wr_addr); end
        n_checks++; if (bus.wr_data !== 2'b00) begin n_fail++; $display("FAIL reset_data: got %b expected 00", bus.wr_data); end
        n_checks++; if (bus.wr_ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack: got %b expected 0000", bus.wr_ack); end
        n_checks++; if (bus.req_ready !== 4'b1111) begin n_fail++; $display("FAIL reset_ready: got %b expected 1111", bus.req_ready); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_single_write();
        do_reset();
        set_req(2, 8'h15, 2'b10);
        tick();
        n_checks++; if (bus.req_ready !== 4'b1011) begin n_fail++; $display("FAIL single_ready_low: got %b expected 1011", bus.req_ready); end
        n_checks++; if (bus.we !== 1'b0) begin n_fail++; $display("FAIL single_we_early: got %b expected 0", bus.we); end
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", bus.busy); end
        clear_inputs();
        tick();
        n_checks++; if (bus.we !== 1'b1) begin n_fail++; $display("FAIL single_we: got %b expected 1", bus.we); end
        n_checks++; if (bus.wr_addr !== 8'h15) begin n_fail++; $display("FAIL single_addr: got %h expected 15", bus.wr_addr); end
        n_checks++; if (bus.wr_data !== 2'b10) begin n_fail++; $display("FAIL single_data: got %b expected 10", bus.wr_data); end
        n_checks++; if (bus.wr_ack !== 4'b0100) begin n_fail++; $display("FAIL single_ack: got %b expected 0100", bus.wr_ack); end
        n_checks++; if (bus.req_ready !== 4'b1111) begin n_fail++; $display("FAIL single_ready_back: got %b expected 1111", bus.req_ready); end
        tick();
        n_checks++; if (bus.we !== 1'b0) begin n_fail++; $display("FAIL single_we_drop: got %b expected 0", bus.we); end
        n_checks++; if (bus.wr_ack !== 4'b0000) begin n_fail++; $display("FAIL single_ack_drop: got %b expected 0000", bus.wr_ack); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %b expected 0", bus.busy); end
    endtask

    task automatic test_all_four();
        logic [AW-1:0] exp_addr [4];
        logic [NR-1:0] exp_ack;
        exp_addr[0] = 8'd10; exp_addr[1] = 8'd20; exp_addr[2] = 8'd30; exp_addr[3] = 8'd40;
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, exp_addr[i], DW'(i));
        tick();
        clear_inputs();
        for (int k = 0; k < NR; k++) begin
            tick();
            exp_ack = '0;
            exp_ack[k] = 1'b1;
            n_checks++; if (bus.we !== 1'b1) begin n_fail++; $display("FAIL all4_we[%0d]: got %b expected 1", k, bus.we); end
            n_checks++; if (bus.wr_addr !== exp_addr[k]) begin n_fail++; $display("FAIL all4_addr[%0d]: got %0d expected %0d", k, bus.wr_addr, exp_addr[k]); end
            n_checks++; if (bus.wr_data !== DW'(k)) begin n_fail++; $display("FAIL all4_data[%0d]: got %0d expected %0d", k, bus.wr_data, k); end
            n_checks++; if (bus.wr_ack !== exp_ack) begin n_fail++; $display("FAIL all4_ack[%0d]: got %b expected %b", k, bus.wr_ack, exp_ack); end
        end
        tick();
        n_checks++; if (bus.we !== 1'b0) begin n_fail++; $display("FAIL all4_we_end: got %b expected 0", bus.we); end
        // rr_ptr back at 0: slot 0 must beat slot 3
        set_req(0, 8'hA0, 2'b01);
        set_req(3, 8'hA3, 2'b11);
        tick();
        clear_inputs();
        tick();
        n_checks++; if (bus.wr_ack !== 4'b0001) begin n_fail++; $display("FAIL all4_rr_zero: got %b expected 0001", bus.wr_ack); end
        tick();
        n_checks++; if (bus.wr_ack !== 4'b1000) begin n_fail++; $display("FAIL all4_rr_zero_next: got %b expected 1000", bus.wr_ack); end
    endtask

    task automatic test_wrap_fairness();
        logic [NR-1:0] exp_first;
        logic [NR-1:0] exp_second;
        do_reset();
        set_req(3, 8'h03, 2'b11);
        tick();
        clear_inputs();
        tick();
        n_checks++; if (bus.wr_ack !== 4'b1000) begin n_fail++; $display("FAIL wrap_slot3: got %b expected 1000", bus.wr_ack); end
        set_req(1, 8'h11, 2'b01);
        set_req(3, 8'h33, 2'b11);
        tick();
        clear_inputs();
        tick();
        n_checks++; if (bus.wr_ack !== 4'b0010) begin n_fail++; $display("FAIL wrap_first: got %b expected 0010", bus.wr_ack); end
        n_checks++; if (bus.wr_addr !== 8'h11) begin n_fail++; $display("FAIL wrap_first_addr: got %h expected 11", bus.wr_addr); end
        tick();
        n_checks++; if (bus.wr_ack !== 4'b1000) begin n_fail++; $display("FAIL wrap_second: got %b expected 1000", bus.wr_ack); end
        n_checks++; if (bus.wr_addr !== 8'h33) begin n_fail++; $display("FAIL wrap_second_addr: got %h expected 33", bus.wr_addr); end
        // Granting slot 2 leaves rr_ptr at 3
        set_req(2, 8'h22, 2'b10);
        tick();
        clear_inputs();
        tick();
        n_checks++; if (bus.wr_ack !== 4'b0100) begin n_fail++; $display("FAIL wrap_slot2: got %b expected 0100", bus.wr_ack); end
`ifdef MAPWR_BOMB_PRIO_EN
        exp_first  = 4'b0001;
        exp_second = 4'b1000;
`else
        exp_first  = 4'b1000;
        exp_second = 4'b0001;
`endif
        set_req(0, 8'h00, 2'b01);
        set_req(3, 8'h30, 2'b11);
        tick();
        clear_inputs();
        tick();
        n_checks++; if (bus.wr_ack !== exp_first) begin n_fail++; $display("FAIL wrap_rr3_first: got %b expected %b", bus.wr_ack, exp_first); end
        tick();
        n_checks++; if (bus.wr_ack !== exp_second) begin n_fail++; $display("FAIL wrap_rr3_second: got %b expected %b", bus.wr_ack, exp_second); end
    endtask

    task automatic test_back_pressure();
        int n_we;
        int n_ack1;
        int n_bad;
        n_we = 0; n_ack1 = 0; n_bad = 0;
        do_reset();
        set_req(1, 8'h5A, 2'b01);
        for (int c = 0; c < 7; c++) begin
            tick();
            if (c == 2) clear_inputs();
            if (bus.we === 1'b1) begin
                n_we++;
                if (bus.wr_addr !== 8'h5A || bus.wr_data !== 2'b01) n_bad++;
            end
            if (bus.wr_ack === 4'b0010) n_ack1++;
            else if (bus.wr_ack !== 4'b0000) n_bad++;
        end
        n_checks++; if (n_we !== 2) begin n_fail++; $display("FAIL bp_writes: got %0d expected 2", n_we); end
        n_checks++; if (n_ack1 !== 2) begin n_fail++; $display("FAIL bp_acks: got %0d expected 2", n_ack1); end
        n_checks++; if (n_bad !== 0) begin n_fail++; $display("FAIL bp_bad_beats: got %0d expected 0", n_bad); end
    endtask

    task automatic test_flush();
        do_reset();
        set_req(0, 8'h01, 2'b01);
        set_req(2, 8'h02, 2'b10);
        tick();
        clear_inputs();
        tick();
        n_checks++; if (bus.wr_ack !== 4'b0001) begin n_fail++; $display("FAIL flush_pre_ack: got %b expected 0001", bus.wr_ack); end
        // Slot 2 still pending, rr_ptr now 1; a request arrives during flush
        bus.flush = 1'b1;
        set_req(3, 8'h77, 2'b11);
        tick();
        n_checks++; if (bus.we !== 1'b0) begin n_fail++; $display("FAIL flush_we: got %b expected 0", bus.we); end
        n_checks++; if (bus.wr_ack !== 4'b0000) begin n_fail++; $display("FAIL flush_ack: got %b expected 0000", bus.wr_ack); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b expected 0", bus.busy); end
        n_checks++; if (bus.req_ready !== 4'b1111) begin n_fail++; $display("FAIL flush_ready: got %b expected 1111", bus.req_ready); end
        clear_inputs();
        tick();
        n_checks++; if (bus.we !== 1'b0) begin n_fail++; $display("FAIL flush_after_we: got %b expected 0", bus.we); end
        set_req(0, 8'h10, 2'b01);
        set_req(3, 8'h13, 2'b11);
        tick();
        clear_inputs();
        tick();
        n_checks++; if (bus.wr_ack !== 4'b0001) begin n_fail++; $display("FAIL flush_rr_reset: got %b expected 0001", bus.wr_ack); end
        tick();
        n_checks++; if (bus.wr_ack !== 4'b1000) begin n_fail++; $display("FAIL flush_rr_next: got %b expected 1000", bus.wr_ack); end
    endtask

    task automatic test_async_reset();
        int n_stale;
        n_stale = 0;
        do_reset();
        set_req(0, 8'h40, 2'b01);
        set_req(1, 8'h41, 2'b10);
        set_req(2, 8'h42, 2'b11);
        tick();
        clear_inputs();
        tick();
        n_checks++; if (bus.we !== 1'b1) begin n_fail++; $display("FAIL arst_pre_we: got %b expected 1", bus.we); end
        rst = 1'b1;
        #1;
        n_checks++; if (bus.we !== 1'b0) begin n_fail++; $display("FAIL arst_we: got %b expected 0", bus.we); end
        n_checks++; if (bus.wr_ack !== 4'b0000) begin n_fail++; $display("FAIL arst_ack: got %b expected 0000", bus.wr_ack); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %b expected 0", bus.busy); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (bus.we !== 1'b0 || bus.wr_ack !== 4'b0000) n_stale++;
        end
        n_checks++; if (n_stale !== 0) begin n_fail++; $display("FAIL arst_stale: got %0d expected 0", n_stale); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_all_four();
        test_wrap_fairness();
        test_back_pressure();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/map_write_arbiter.md
Name: map_write_arbiter

Overview:
Round-robin write arbiter for the shared map memory write port. It serializes tile writes from bomb placement, block clearing and power-up spawning for both players. Each requester has a valid/ready handshake and a one-entry pending buffer. The block drives the single registered we/wr_addr/wr_data triple into map_mem, so writes from different requesters can neither collide nor be lost.

Parameters:
NUM_REQ, 4, number of write requesters (2..8); index 0 = P1 bomb, 1 = P2 bomb, 2 = P1 free_blocks, 3 = P2 free_blocks
ADDR_WIDTH, 8, map address width ($clog2(19*11))
DATA_WIDTH, 2, tile state width

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous reset, active-high
flush  in  1  synchronous clear of all pending writes (round restart)
req_valid  in  NUM_REQ  per-requester write request
req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; slice i = [i*ADDR_WIDTH +: ADDR_WIDTH]
req_data  in  NUM_REQ*DATA_WIDTH  packed data, same packing
req_ready  out  NUM_REQ  requester slot free
wr_ack  out  NUM_REQ  one-cycle pulse, coincident with that requester's memory write
we  out  1  map_mem write enable
wr_addr  out  ADDR_WIDTH  map_mem write address
wr_data  out  DATA_WIDTH  map_mem write data
busy  out  1  any write pending or issuing

Behaviour:
- Reset (async, rst=1): pending = 0, all slot regs = 0, rr_ptr = 0, we = 0, wr_addr = 0, wr_data = 0, wr_ack = 0. req_ready = 1 for all slots once rst deasserts. busy = 0.
- Handshake:
  - req_ready[i] = ~pending[i] (combinational from a register).
  - Transfer occurs on a rising edge when req_valid[i] & req_ready[i]. That edge captures addr/data into slot i and sets pending[i].
  - A requester holds valid/addr/data stable until transfer.
- Arbitration (combinational, per cycle): scan pending starting at rr_ptr, wrapping modulo NUM_REQ (non-power-of-2 wrap required). The first set bit k is granted.
- Grant edge:
  - we <= 1, wr_addr <= slot_addr[k], wr_data <= slot_data[k].
  - wr_ack <= one-hot(k); pending[k] <= 0.
  - rr_ptr <= (k+1) mod NUM_REQ.
  - No pending: we <= 0, wr_ack <= 0, rr_ptr holds.
- Latency: transfer at edge N; earliest we/wr_ack high in cycle after edge N+1. req_ready[i] returns high in that same cycle. Per-requester throughput is 1 write per 2 cycles. Aggregate throughput is 1 write per cycle when ≥2 slots are busy.
- Simultaneous events:
  - All slots pending: grants in rr order. With rr_ptr=2 and NUM_REQ=4, order is 2,3,0,1.
  - A slot cannot be accepted and granted on the same edge (ready low while pending).
  - Back-to-back writes to the same address are issued in grant order; the last one wins.
- flush (priority over accept and grant):
  - pending <= 0; we <= 0; wr_ack <= 0; rr_ptr <= 0.
  - Requests presented during flush are not accepted.
  - A write already registered (we high in the flush cycle) completes.
- busy = |pending | we.
- Two-state per slot FSM: EMPTY → (valid&ready) → PENDING → (granted or flush) → EMPTY.
- Reset mid-operation: all pending writes are discarded; no ack is issued.

Optional Feature:
MAPWR_BOMB_PRIO_EN
- Defined: bomb requesters (indices 0 and 1) form a fixed-priority tier above round-robin. Index 0 beats 1. If either is pending it is granted regardless of rr_ptr, and rr_ptr is not updated. Round-robin applies only when neither bomb slot is pending. This guarantees a bomb tile write lands within 2 cycles of acceptance, even under free_blocks bursts.
- Undefined: pure round-robin over all NUM_REQ slots, as above.

Test Plan:
1. Reset then single write: slot 2 valid, addr=0x15, data=2'b10 at edge N → we=1, wr_addr=0x15, wr_data=2'b10, wr_ack=4'b0100 for exactly one cycle after edge N+1. req_ready[2]=0 for one cycle only.
2. All four slots valid on the same edge with rr_ptr=0, addrs 10,20,30,40 → we high for 4 consecutive cycles with wr_addr 10,20,30,40. Acks are one-hot 0001,0010,0100,1000; final rr_ptr=0.
3. Wrap fairness: slot 3 granted (rr_ptr→0), then slots 1 and 3 pending → slot 1 first, then 3. With MAPWR_BOMB_PRIO_EN: slot 1 first in every case; slot 0 pending alongside slot 3 beats it even with rr_ptr=3.
4. Back-pressure: slot 1 holds valid for 3 consecutive cycles → exactly two writes issued (accept, grant, re-accept), never three. Stable addr is written twice, with no lost or duplicated ack.
5. flush with slots 0 and 2 pending → no we, no wr_ack in following cycles; busy=0 and req_ready=4'b1111 on the next cycle; rr_ptr=0.
6. Async reset asserted mid-burst (2 pending, we=1) → we, wr_ack and busy drop without waiting for a clock edge. After release, no stale write is issued.
